// File: rtl/eu_dispatch_alloc.sv
// Dispatch allocator: places every valid lane of a renamed batch onto an execution
// unit with free issue-queue credit, round-robin from rr_ptr, all-or-nothing per batch.
module eu_dispatch_alloc #(
    parameter int NUM_PARALLEL_INSTR_DISPATCHES = 4,
    parameter int LOG2_NUM_EXEC_UNITS           = 2,
    parameter int EU_CREDITS                    = 64,
    parameter int CREDIT_W                      = $clog2(EU_CREDITS + 1),
    parameter int INSTR_W                       = 32
) (
    input  logic                                                        clk,
    input  logic                                                        reset_n,
    input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][INSTR_W-1:0]             batch_instr_i,
    input  logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                          batch_valid_i,
    input  logic                                                        batch_req_i,
    output logic                                                        batch_ack_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][INSTR_W-1:0]             dispatched_instr_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0]                          dispatched_instr_valid_o,
    output logic [NUM_PARALLEL_INSTR_DISPATCHES-1:0][LOG2_NUM_EXEC_UNITS-1:0] dispatched_instr_alloc_euidx_o,
    input  logic [(1<<LOG2_NUM_EXEC_UNITS)-1:0]                               eu_issue_i,
    input  logic [(1<<LOG2_NUM_EXEC_UNITS)-1:0]                               eu_iqueue_full_i,
    output logic                                                        stalled_o,
    output logic                                                        credit_err_o,
    output logic [1:0]                                                  dbg_state_o,
    output logic [LOG2_NUM_EXEC_UNITS-1:0]                                    dbg_rr_ptr_o,
    output logic [(1<<LOG2_NUM_EXEC_UNITS)-1:0][CREDIT_W-1:0]                 dbg_credit_o
);
    localparam int N      = NUM_PARALLEL_INSTR_DISPATCHES;
    localparam int L      = LOG2_NUM_EXEC_UNITS;
    localparam int NUM_EU = 1 << L;

    // Handshake: batch_req_i is held with stable batch_*_i until batch_ack_o is seen
    // high on a rising edge; ack is combinational in that same cycle.
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_STALL    = 2'd1,
        S_DISPATCH = 2'd2
    } state_t;

    state_t                                 r_state;
    state_t                                 w_state_nxt;
    logic [NUM_EU-1:0][CREDIT_W-1:0]        r_credit;
    logic [NUM_EU-1:0][CREDIT_W-1:0]        w_credit_nxt;
    logic [NUM_EU-1:0][CREDIT_W-1:0]        w_tent;
    logic [L-1:0]                           r_rr_ptr;
    logic [N-1:0]                           r_dv;
    logic [N-1:0][L-1:0]                    r_euidx;
    logic [N-1:0][INSTR_W-1:0]              r_instr;
    logic                                   r_err;
    logic [N-1:0][L-1:0]                    w_euidx;
    logic [L-1:0]                           w_cursor;
    logic [L-1:0]                           w_probe;
    logic [L-1:0]                           w_pick;
    logic                                   w_found;
    logic                                   w_fits;
    logic                                   w_ack;
    logic                                   w_err_set;
    logic [CREDIT_W-1:0]                    w_base;

    // Tentative placement: w_tent tracks credit left after earlier lanes of this batch.
    always_comb begin
        w_tent   = r_credit;
        w_cursor = r_rr_ptr;
        w_fits   = 1'b1;
        w_euidx  = '0;
        w_probe  = '0;
        w_pick   = '0;
        w_found  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (batch_valid_i[i]) begin
                w_found = 1'b0;
                w_pick  = '0;
                for (int k = 0; k < NUM_EU; k++) begin
                    w_probe = w_cursor + L'(k);
                    if (!w_found && (w_tent[w_probe] != '0)) begin
                        w_found = 1'b1;
                        w_pick  = w_probe;
                    end
                end
                if (w_found) begin
                    w_tent[w_pick] = w_tent[w_pick] - CREDIT_W'(1);
                    w_euidx[i]     = w_pick;
                    w_cursor       = w_pick + L'(1);
                end else begin
                    w_fits = 1'b0;
                end
            end
        end
    end

    assign w_ack = reset_n & batch_req_i & w_fits;

    // IDLE, STALL and DISPATCH share one transition rule; only stalled_o tells them apart.
    always_comb begin
        w_state_nxt = S_IDLE;
        if (batch_req_i) begin
            w_state_nxt = w_fits ? S_DISPATCH : S_STALL;
        end
    end

    always_comb begin
        w_credit_nxt = r_credit;
        w_err_set    = 1'b0;
        w_base       = '0;
        for (int e = 0; e < NUM_EU; e++) begin
            w_base = w_ack ? w_tent[e] : r_credit[e];
            if (eu_issue_i[e]) begin
                if (w_base == CREDIT_W'(EU_CREDITS)) begin
                    w_err_set = 1'b1;
                end else begin
                    w_base = w_base + CREDIT_W'(1);
                end
            end
            if (eu_iqueue_full_i[e] && (r_credit[e] != '0)) begin
                w_err_set = 1'b1;
            end
            w_credit_nxt[e] = w_base;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_credit <= {NUM_EU{CREDIT_W'(EU_CREDITS)}};
            r_rr_ptr <= '0;
            r_dv     <= '0;
            r_euidx  <= '0;
            r_instr  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_credit <= w_credit_nxt;
            if (w_ack) begin
                r_rr_ptr <= w_cursor;
            end
            r_dv    <= w_ack ? batch_valid_i : '0;
            r_euidx <= w_ack ? w_euidx : '0;
            r_instr <= w_ack ? batch_instr_i : '0;
            r_err   <= r_err | w_err_set;
        end
    end

    assign batch_ack_o                    = w_ack;
    assign dispatched_instr_o             = r_instr;
    assign dispatched_instr_valid_o       = r_dv;
    assign dispatched_instr_alloc_euidx_o = r_euidx;
    assign stalled_o                      = (r_state == S_STALL);
    assign credit_err_o                   = r_err;
    assign dbg_state_o                    = r_state;
    assign dbg_rr_ptr_o                   = r_rr_ptr;
    assign dbg_credit_o                   = r_credit;

endmodule

// File: tb/tb_eu_dispatch_alloc.sv
// Bench for eu_dispatch_alloc: 4 lanes, 4 EUs, 4 credits each; directed batches
// checked every cycle against a credit/round-robin model plus literal expectations.
module tb_eu_dispatch_alloc;
  localparam int N  = 4;
  localparam int L  = 2;
  localparam int NE = 4;
  localparam int EC = 4;
  localparam int CW = 3;
  localparam int IW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N-1:0][IW-1:0] batch_instr_i = '0;
  logic [N-1:0] batch_valid_i = '0;
  logic batch_req_i = 1'b0;
  logic batch_ack_o;
  logic [N-1:0][IW-1:0] dispatched_instr_o;
  logic [N-1:0] dispatched_instr_valid_o;
  logic [N-1:0][L-1:0] dispatched_instr_alloc_euidx_o;
  logic [NE-1:0] eu_issue_i = '0;
  logic [NE-1:0] eu_iqueue_full_i = '0;
  logic stalled_o;
  logic credit_err_o;
  logic [1:0] dbg_state_o;
  logic [L-1:0] dbg_rr_ptr_o;
  logic [NE-1:0][CW-1:0] dbg_credit_o;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model state: values the registered outputs must hold in the current cycle.
  int m_cred[NE];
  int m_rr;
  bit m_stall, m_err;
  logic [N-1:0] m_dv;
  logic [L-1:0] m_eu[N];
  logic [IW-1:0] m_instr[N];

  eu_dispatch_alloc #(
    .NUM_PARALLEL_INSTR_DISPATCHES(N),
    .LOG2_NUM_EXEC_UNITS(L),
    .EU_CREDITS(EC),
    .CREDIT_W(CW),
    .INSTR_W(IW)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .batch_instr_i(batch_instr_i),
    .batch_valid_i(batch_valid_i),
    .batch_req_i(batch_req_i),
    .batch_ack_o(batch_ack_o),
    .dispatched_instr_o(dispatched_instr_o),
    .dispatched_instr_valid_o(dispatched_instr_valid_o),
    .dispatched_instr_alloc_euidx_o(dispatched_instr_alloc_euidx_o),
    .eu_issue_i(eu_issue_i),
    .eu_iqueue_full_i(eu_iqueue_full_i),
    .stalled_o(stalled_o),
    .credit_err_o(credit_err_o),
    .dbg_state_o(dbg_state_o),
    .dbg_rr_ptr_o(dbg_rr_ptr_o),
    .dbg_credit_o(dbg_credit_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in the cycle after acceptance, when the dispatch pulse is visible.
  task automatic drive_batch(input logic [N-1:0] v);
    bit acked;
    bit a;
    acked = 0;
    batch_valid_i = v;
    for (int l = 0; l < N; l++) batch_instr_i[l] = $urandom();
    batch_req_i = 1'b1;
    for (int c = 0; c < 20 && !acked; c++) begin
      @(negedge clk);
      a = batch_ack_o;
      tick();
      if (a) acked = 1;
    end
    batch_req_i = 1'b0;
    batch_valid_i = '0;
    if (!acked) chk("ack_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    for (int e = 0; e < NE; e++) m_cred[e] = EC;
    m_rr = 0;
    m_stall = 0;
    m_err = 0;
    m_dv = '0;
    for (int l = 0; l < N; l++) begin
      m_eu[l] = '0;
      m_instr[l] = '0;
    end
  end

  // Compare, then advance the model across the coming rising edge.
  initial begin : compare_proc
    int tent[NE];
    int cur;
    int e;
    int base;
    bit fits;
    bit ack;
    logic [L-1:0] eu_l[N];
    forever begin
      @(negedge clk);
      tent = m_cred;
      cur = m_rr;
      fits = 1;
      for (int l = 0; l < N; l++) begin
        eu_l[l] = '0;
        if (batch_valid_i[l]) begin
          e = -1;
          for (int k = 0; k < NE; k++)
            if (e < 0 && tent[(cur + k) % NE] > 0) e = (cur + k) % NE;
          if (e < 0) fits = 0;
          else begin
            tent[e]--;
            eu_l[l] = e[L-1:0];
            cur = (e + 1) % NE;
          end
        end
      end
      ack = reset_n && batch_req_i && fits;
      if (chk_en) begin
        chk("ack", batch_ack_o, ack);
        chk("stalled", stalled_o, m_stall);
        chk("credit_err", credit_err_o, m_err);
        chk("valid", dispatched_instr_valid_o, m_dv);
        chk("rr_ptr", dbg_rr_ptr_o, m_rr);
        for (int l = 0; l < N; l++) begin
          chk("euidx", dispatched_instr_alloc_euidx_o[l], m_eu[l]);
          chk("instr", dispatched_instr_o[l], m_instr[l]);
        end
        for (int q = 0; q < NE; q++) chk("credit", dbg_credit_o[q], m_cred[q]);
      end
      if (!reset_n) begin
        for (int q = 0; q < NE; q++) m_cred[q] = EC;
        m_rr = 0;
        m_stall = 0;
        m_err = 0;
        m_dv = '0;
        for (int l = 0; l < N; l++) begin
          m_eu[l] = '0;
          m_instr[l] = '0;
        end
      end else begin
        for (int q = 0; q < NE; q++) begin
          base = ack ? tent[q] : m_cred[q];
          if (eu_iqueue_full_i[q] && m_cred[q] > 0) m_err = 1;
          if (eu_issue_i[q]) begin
            if (base == EC) m_err = 1;
            else base++;
          end
          m_cred[q] = base;
        end
        if (ack) m_rr = cur;
        m_stall = batch_req_i && !ack;
        m_dv = ack ? batch_valid_i : '0;
        for (int l = 0; l < N; l++) begin
          m_eu[l] = ack ? eu_l[l] : '0;
          m_instr[l] = ack ? batch_instr_i[l] : '0;
        end
      end
    end
  end

  initial begin
    reset_n = 1'b0;
    @(posedge clk);
    chk_en = 1;
    #1;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_credits", dbg_credit_o, 12'h924);
    chk("rst_valid", dispatched_instr_valid_o, 4'b0000);
    chk("rst_stalled", stalled_o, 1'b0);
    tick();

    // Full batch: EUs 0..3, rr wraps back to 0, each credit 3.
    batch_valid_i = 4'b1111;
    batch_req_i = 1'b1;
    @(negedge clk);
    chk("lit_ack_same_cycle", batch_ack_o, 1'b1);
    batch_req_i = 1'b0;
    batch_req_i = 1'b1;
    tick();
    batch_req_i = 1'b0;
    batch_valid_i = '0;
    @(negedge clk);
    chk("lit_full_euidx", dispatched_instr_alloc_euidx_o, 8'hE4);
    chk("lit_full_valid", dispatched_instr_valid_o, 4'b1111);
    chk("lit_full_rr", dbg_rr_ptr_o, 2'd0);
    chk("lit_full_credits", dbg_credit_o, 12'h6DB);
    tick();

    // Sparse batch: lanes 0,2 -> EUs 0,1; credits 2,2,3,3.
    drive_batch(4'b0101);
    @(negedge clk);
    chk("lit_sparse_euidx", dispatched_instr_alloc_euidx_o, 8'h10);
    chk("lit_sparse_valid", dispatched_instr_valid_o, 4'b0101);
    chk("lit_sparse_rr", dbg_rr_ptr_o, 2'd2);
    tick();

    // Drain EU1 to zero and leave rr_ptr at 1.
    drive_batch(4'b1111);
    drive_batch(4'b0111);
    drive_batch(4'b0001);
    eu_issue_i = 4'b0001;
    tick();
    eu_issue_i = '0;
    drive_batch(4'b0111);
    eu_issue_i = 4'b1100;
    tick();
    eu_issue_i = '0;
    @(negedge clk);
    chk("lit_pre_skip_rr", dbg_rr_ptr_o, 2'd1);
    chk("lit_pre_skip_credits", dbg_credit_o, 12'h240);
    tick();
    drive_batch(4'b0011);
    @(negedge clk);
    chk("lit_skip_euidx", dispatched_instr_alloc_euidx_o, 8'h0E);
    chk("lit_skip_credits", dbg_credit_o, 12'h000);
    tick();

    // All credits zero: stall until EU2 returns one.
    batch_valid_i = 4'b0001;
    batch_req_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("lit_stall", stalled_o, 1'b1);
    chk("lit_stall_noack", batch_ack_o, 1'b0);
    tick();
    eu_issue_i = 4'b0100;
    @(negedge clk);
    chk("lit_return_not_seen", batch_ack_o, 1'b0);
    tick();
    eu_issue_i = '0;
    @(negedge clk);
    chk("lit_unstall_ack", batch_ack_o, 1'b1);
    tick();
    batch_req_i = 1'b0;
    batch_valid_i = '0;
    @(negedge clk);
    chk("lit_unstall_stalled", stalled_o, 1'b0);
    chk("lit_unstall_euidx", dispatched_instr_alloc_euidx_o, 8'h02);
    chk("lit_unstall_rr", dbg_rr_ptr_o, 2'd3);
    tick();

    // Allocation and return on EU0 in the same cycle net out.
    eu_issue_i = 4'b0001;
    tick();
    drive_batch(4'b0001);
    eu_issue_i = '0;
    @(negedge clk);
    chk("lit_net_credit0", dbg_credit_o[0], 3'd1);
    chk("lit_net_euidx", dispatched_instr_alloc_euidx_o, 8'h00);
    tick();
    eu_issue_i = 4'b1110;
    for (int i = 0; i < 4; i++) tick();
    eu_issue_i = 4'b0001;
    for (int i = 0; i < 3; i++) tick();
    eu_issue_i = '0;
    @(negedge clk);
    chk("lit_refill", dbg_credit_o, 12'h924);
    chk("lit_refill_err", credit_err_o, 1'b0);
    tick();
    eu_issue_i = 4'b0001;
    tick();
    eu_issue_i = '0;
    @(negedge clk);
    chk("lit_sat_credit0", dbg_credit_o[0], 3'd4);
    chk("lit_sat_err", credit_err_o, 1'b1);
    tick();
    tick();
    tick();
    @(negedge clk);
    chk("lit_err_sticky", credit_err_o, 1'b1);

    // Reset clears the error; full flag with credit left sets it again.
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("lit_err_cleared", credit_err_o, 1'b0);
    tick();
    eu_iqueue_full_i = 4'b0010;
    tick();
    eu_iqueue_full_i = '0;
    @(negedge clk);
    chk("lit_full_err", credit_err_o, 1'b1);
    tick();

    // Reset while stalled drops the held batch.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) drive_batch(4'b1111);
    batch_valid_i = 4'b0001;
    batch_req_i = 1'b1;
    tick();
    tick();
    @(negedge clk);
    chk("lit_stall2", stalled_o, 1'b1);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("lit_rst_ack_gated", batch_ack_o, 1'b0);
    tick();
    reset_n = 1'b1;
    batch_req_i = 1'b0;
    batch_valid_i = '0;
    @(negedge clk);
    chk("lit_rst_stall_valid", dispatched_instr_valid_o, 4'b0000);
    chk("lit_rst_stall_ack", batch_ack_o, 1'b0);
    chk("lit_rst_stall_credits", dbg_credit_o, 12'h924);
    chk("lit_rst_stall_stalled", stalled_o, 1'b0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/eu_dispatch_alloc.md
Name: eu_dispatch_alloc

Overview:
- Front-end dispatch allocator. Takes a batch of renamed instructions and assigns each valid lane an execution-unit index.
- Tracks per-EU issue-queue occupancy with credit counters and drives the dispatch bus (instr, valid, alloc_euidx) seen by every EU issue queue.
- Accepts a batch only when every valid lane can be placed. It never partially dispatches, so EU issue queues never report full in normal operation.

Parameters:
- NUM_PARALLEL_INSTR_DISPATCHES, 4: lanes per dispatch batch.
- LOG2_NUM_EXEC_UNITS, 2: NUM_EU = 2**LOG2_NUM_EXEC_UNITS.
- EU_CREDITS, 64: entries per EU issue queue (NUM_QUEUES * 2**LOG2_QUEUE_LENGTH). Must be ≥ NUM_PARALLEL_INSTR_DISPATCHES.
- CREDIT_W, $clog2(EU_CREDITS+1): credit counter width.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset
- batch_instr_i  in  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES]  renamed instructions
- batch_valid_i  in  1 [NUM_PARALLEL_INSTR_DISPATCHES]  per-lane valid; lanes may be sparse
- batch_req_i  in  1  batch present
- batch_ack_o  out  1  batch accepted this cycle
- dispatched_instr_o  out  type_iqueue_entry [NUM_PARALLEL_INSTR_DISPATCHES]  to all EU issue queues
- dispatched_instr_valid_o  out  1 [NUM_PARALLEL_INSTR_DISPATCHES]  lane valid
- dispatched_instr_alloc_euidx_o  out  LOG2_NUM_EXEC_UNITS [NUM_PARALLEL_INSTR_DISPATCHES]  target EU
- eu_issue_i  in  1 [NUM_EU]  EU popped one entry (curr_instr_to_exec_valid & ready_for_next_instr)
- eu_iqueue_full_i  in  1 [NUM_EU]  EU issue queue is_full_o (checker only)
- stalled_o  out  1  FSM in STALL
- credit_err_o  out  1  sticky protocol error

Behaviour:
- Reset is synchronous, active-low on reset_n; clock is clk. Reset takes effect at the next posedge and dominates all other inputs.
- Reset values:
  - all credits = EU_CREDITS; rr_ptr = 0; state = IDLE
  - batch_ack_o = 0; all dispatched_*_o = 0; stalled_o = 0; credit_err_o = 0
- Allocation (combinational on the held batch):
  - Walk lanes 0..N-1 in order. Each valid lane takes the first EU, searching cyclically from cursor, whose credit minus tentative allocations earlier in this batch is > 0. The cursor starts at rr_ptr and advances to chosen EU + 1 after each placement.
  - Invalid lanes get euidx 0 and do not move the cursor.
  - fits = every valid lane placed.
- FSM states:
  - IDLE:
    - batch_req_i & fits: ack, go DISPATCH.
    - batch_req_i & ~fits: go STALL.
    - otherwise: stay.
  - STALL: stalled_o = 1. Re-evaluate each cycle using updated credits. On fits: ack, go DISPATCH. If batch_req_i drops, go IDLE with no error.
  - DISPATCH: registered outputs are valid this cycle only (one-cycle pulse). From here, same transitions as IDLE, so back-to-back batches are allowed.
- Latency: batch_ack_o is combinational in the acceptance cycle. Dispatch outputs appear on the next cycle.
- Handshake: the front end holds batch_*_i stable while batch_req_i & ~batch_ack_o.
- rr_ptr on accept: rr_ptr <= last chosen EU + 1, mod NUM_EU. Unchanged if the batch has no valid lanes; an all-invalid batch is acked and emits all-zero valids.
- Credit update per EU, every cycle: credit <= credit - alloc_count + eu_issue_i.
  - Allocation and return in the same cycle net out.
  - A return in the acceptance cycle is not visible to that cycle's fits.
- Boundaries:
  - Credit 0 EU is skipped.
  - All credits 0 with any valid lane: STALL.
  - Return while credit == EU_CREDITS: saturate, set credit_err_o.
  - eu_iqueue_full_i high in a cycle where that EU's credit > 0: set credit_err_o.
  - credit_err_o is cleared only by reset.
- Reset mid-STALL or mid-DISPATCH: outputs are 0 next cycle and the held batch is dropped (not acked).

Test Plan:
- Reset with NUM_EU=4, EU_CREDITS=4, batch_valid_i=1111 → batch_ack_o=1 same cycle; next cycle alloc_euidx={0,1,2,3}, valid=1111; rr_ptr=0; every credit = 3.
- Sparse batch valid=0101 after the previous batch → lanes 0,2 get EUs 0,1; lanes 1,3 have valid=0 and euidx=0; rr_ptr=2.
- Drain EU1 to credit 0 via batches, then send valid=0011 with rr_ptr=1 → lanes get EUs 2,3; EU1 is skipped.
- All credits 0, batch valid=0001 → stalled_o=1, no ack. Pulse eu_issue_i[2] → next cycle ack, euidx=2, and stalled_o drops.
- Same-cycle ack allocating EU0 plus eu_issue_i[0] → EU0 credit unchanged. Then eu_issue_i[0] with EU0 at 4 → credit stays 4 and credit_err_o=1 until reset.
- Assert reset_n=0 while in STALL → next cycle dispatched_instr_valid_o=0000, batch_ack_o=0, credits=4, stalled_o=0.
